// File: rtl/scoreboard_ctrl_if.sv
// rtl/scoreboard_ctrl_if.sv - issue-queue to hazard-scheduler signal bundle
interface scoreboard_ctrl_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic               stall_adv;
    logic               flash_ex;
    logic [1:0]         cand_valid;
    logic [4*AW-1:0]    cand_src_addr;
    logic [3:0]         cand_src_use;
    logic [2*AW-1:0]    cand_dst_addr;
    logic [1:0]         cand_dst_we;
    logic [1:0]         cand_load;
    logic [1:0]         issue_num;
    logic [11:0]        src_sel;
    logic [CNT_W-1:0]   hazard_stall_cnt;

    // Issue-queue / pipeline-control side
    modport master (
        output stall_adv, flash_ex, cand_valid, cand_src_addr, cand_src_use,
               cand_dst_addr, cand_dst_we, cand_load,
        input  issue_num, src_sel, hazard_stall_cnt
    );

    // Scheduler side
    modport slave (
        input  stall_adv, flash_ex, cand_valid, cand_src_addr, cand_src_use,
               cand_dst_addr, cand_dst_we, cand_load,
        output issue_num, src_sel, hazard_stall_cnt
    );
endinterface

// File: rtl/scoreboard_ctrl.sv
// rtl/scoreboard_ctrl.sv - dual-issue hazard scheduler with EX/MEM/CMT writer shadows
module scoreboard_ctrl #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    scoreboard_ctrl_if.slave  sb
);
    // Shadow entries per stage, index = lane. Only EX needs the load flag:
    // once a load reaches MEM its result is bypassable at the end of MEM.
    logic [1:0]         ex_v_q, mem_v_q, cmt_v_q;
    logic [1:0][AW-1:0] ex_a_q, mem_a_q, cmt_a_q;
    logic [1:0]         ex_l_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [3:0][2:0]    sel;
    logic [3:0]         rdy;
    logic [3:0][AW-1:0] src;
    logic [1:0][AW-1:0] dst;
    logic               raw;
    logic               iss0;
    logic               iss1;
    logic               blocked;

    // Unpack the flat candidate buses
    always_comb begin
        for (int j = 0; j < 4; j++) src[j] = sb.cand_src_addr[j*AW +: AW];
        for (int i = 0; i < 2; i++) dst[i] = sb.cand_dst_addr[i*AW +: AW];
    end

    // Youngest-first producer lookup and readiness for every source operand
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            sel[j] = 3'd0;
            rdy[j] = 1'b1;
            if (sb.cand_src_use[j] && (src[j] != '0)) begin
                if (ex_v_q[1] && (ex_a_q[1] == src[j])) begin
                    sel[j] = 3'd2;
                    rdy[j] = ~ex_l_q[1];
                end else if (ex_v_q[0] && (ex_a_q[0] == src[j])) begin
                    sel[j] = 3'd1;
                    rdy[j] = ~ex_l_q[0];
                end else if (mem_v_q[1] && (mem_a_q[1] == src[j])) begin
                    sel[j] = 3'd4;
                end else if (mem_v_q[0] && (mem_a_q[0] == src[j])) begin
                    sel[j] = 3'd3;
                end else if (cmt_v_q[1] && (cmt_a_q[1] == src[j])) begin
                    sel[j] = 3'd6;
                end else if (cmt_v_q[0] && (cmt_a_q[0] == src[j])) begin
                    sel[j] = 3'd5;
                end
            end
        end
    end

    // In-order issue decision; candidate 1 never issues alone
    always_comb begin
        raw = sb.cand_dst_we[0] && (dst[0] != '0) &&
              ((sb.cand_src_use[2] && (src[2] == dst[0])) ||
               (sb.cand_src_use[3] && (src[3] == dst[0])));
        iss0 = sb.cand_valid[0] && rdy[0] && rdy[1] && !sb.stall_adv && !sb.flash_ex;
        iss1 = iss0 && sb.cand_valid[1] && rdy[2] && rdy[3] && !raw;
        blocked = sb.cand_valid[0] && !sb.stall_adv && !sb.flash_ex && !(rdy[0] && rdy[1]);
    end

    assign sb.issue_num        = {1'b0, iss0} + {1'b0, iss1};
    assign sb.src_sel          = {sel[3], sel[2], sel[1], sel[0]};
    assign sb.hazard_stall_cnt = cnt_q;

    // Shadow pipeline: advance when not stalled; a flash kills EX so nothing moves into MEM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_v_q  <= '0;
            mem_v_q <= '0;
            cmt_v_q <= '0;
            ex_a_q  <= '0;
            mem_a_q <= '0;
            cmt_a_q <= '0;
            ex_l_q  <= '0;
        end else if (sb.stall_adv) begin
            if (sb.flash_ex) ex_v_q <= '0;
        end else begin
            cmt_v_q <= mem_v_q;
            cmt_a_q <= mem_a_q;
            mem_v_q <= sb.flash_ex ? 2'b00 : ex_v_q;
            mem_a_q <= ex_a_q;
            ex_v_q  <= {iss1 && sb.cand_dst_we[1] && (dst[1] != '0),
                        iss0 && sb.cand_dst_we[0] && (dst[0] != '0)};
            ex_a_q  <= dst;
            ex_l_q  <= sb.cand_load;
        end
    end

    // Saturating count of cycles where the oldest candidate waited on a data hazard
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (blocked && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb/tb_scoreboard_ctrl.sv - directed self-checking bench for scoreboard_ctrl
module tb_scoreboard_ctrl;
    localparam int AW    = 5;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    scoreboard_ctrl_if #(.AW(AW), .CNT_W(CNT_W)) sif ();

    scoreboard_ctrl #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sif.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cands();
        sif.stall_adv     = 1'b0;
        sif.flash_ex      = 1'b0;
        sif.cand_valid    = '0;
        sif.cand_src_addr = '0;
        sif.cand_src_use  = '0;
        sif.cand_dst_addr = '0;
        sif.cand_dst_we   = '0;
        sif.cand_load     = '0;
    endtask

    task automatic cand(input int i, input logic v, input logic [AW-1:0] s0,
                        input logic [AW-1:0] s1, input logic [1:0] u,
                        input logic [AW-1:0] d, input logic we, input logic ld);
        sif.cand_valid[i]                 = v;
        sif.cand_src_addr[(2*i)*AW +: AW]   = s0;
        sif.cand_src_addr[(2*i+1)*AW +: AW] = s1;
        sif.cand_src_use[2*i +: 2]          = u;
        sif.cand_dst_addr[i*AW +: AW]       = d;
        sif.cand_dst_we[i]                  = we;
        sif.cand_load[i]                    = ld;
    endtask

    task automatic do_reset();
        clear_cands();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (sif.issue_num !== 2'd0) begin
            $display("FAIL reset_issue got %0d want 0", sif.issue_num); miscompares++;
        end
        vectors++;
        if (sif.src_sel !== 12'd0) begin
            $display("FAIL reset_src_sel got %h want 0", sif.src_sel); miscompares++;
        end
        vectors++;
        if (sif.hazard_stall_cnt !== 4'd0) begin
            $display("FAIL reset_cnt got %0d want 0", sif.hazard_stall_cnt); miscompares++;
        end
    endtask

    task automatic test_independent();
        logic [2:0] exp_sel [3];
        exp_sel[0] = 3'd1; exp_sel[1] = 3'd3; exp_sel[2] = 3'd5;
        do_reset();
        cand(0, 1, 0, 0, 2'b00, 5'd3, 1, 0);
        cand(1, 1, 5'd5, 5'd6, 2'b11, 0, 0, 0);
        #1;
        vectors++;
        if (sif.issue_num !== 2'd2) begin
            $display("FAIL indep_issue got %0d want 2", sif.issue_num); miscompares++;
        end
        vectors++;
        if (sif.src_sel !== 12'd0) begin
            $display("FAIL indep_sel got %h want 0", sif.src_sel); miscompares++;
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            clear_cands();
            cand(0, 1, 5'd3, 0, 2'b01, 0, 0, 0);
            #1;
            vectors++;
            if (sif.src_sel[2:0] !== exp_sel[k]) begin
                $display("FAIL indep_age%0d got %0d want %0d", k, sif.src_sel[2:0], exp_sel[k]);
                miscompares++;
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        cand(0, 1, 0, 0, 2'b00, 5'd4, 1, 1);
        tick();
        cand(0, 1, 5'd4, 0, 2'b01, 0, 0, 0);
        #1;
        vectors++;
        if (sif.issue_num !== 2'd0) begin
            $display("FAIL lu_issue got %0d want 0", sif.issue_num); miscompares++;
        end
        vectors++;
        if (sif.hazard_stall_cnt !== 4'd0) begin
            $display("FAIL lu_cnt0 got %0d want 0", sif.hazard_stall_cnt); miscompares++;
        end
        tick();
        #1;
        vectors++;
        if (sif.hazard_stall_cnt !== 4'd1) begin
            $display("FAIL lu_cnt1 got %0d want 1", sif.hazard_stall_cnt); miscompares++;
        end
        vectors++;
        if (sif.issue_num !== 2'd1) begin
            $display("FAIL lu_issue_after got %0d want 1", sif.issue_num); miscompares++;
        end
        vectors++;
        if (sif.src_sel[2:0] !== 3'd3) begin
            $display("FAIL lu_sel got %0d want 3", sif.src_sel[2:0]); miscompares++;
        end
    endtask

    task automatic test_intra_raw();
        do_reset();
        cand(0, 1, 0, 0, 2'b00, 5'd7, 1, 0);
        cand(1, 1, 5'd7, 0, 2'b01, 5'd8, 1, 0);
        #1;
        vectors++;
        if (sif.issue_num !== 2'd1) begin
            $display("FAIL raw_issue got %0d want 1", sif.issue_num); miscompares++;
        end
        tick();
        clear_cands();
        cand(0, 1, 5'd7, 5'd8, 2'b11, 0, 0, 0);
        #1;
        vectors++;
        if (sif.src_sel[5:0] !== {3'd0, 3'd1}) begin
            $display("FAIL raw_sel got %h want 01 (r8 must not be tracked)", sif.src_sel[5:0]);
            miscompares++;
        end
    endtask

    task automatic test_waw();
        do_reset();
        cand(0, 1, 0, 0, 2'b00, 5'd9, 1, 0);
        cand(1, 1, 0, 0, 2'b00, 5'd9, 1, 0);
        #1;
        vectors++;
        if (sif.issue_num !== 2'd2) begin
            $display("FAIL waw_issue got %0d want 2", sif.issue_num); miscompares++;
        end
        tick();
        clear_cands();
        cand(0, 1, 0, 5'd9, 2'b10, 0, 0, 0);
        #1;
        vectors++;
        if (sif.src_sel[5:3] !== 3'd2) begin
            $display("FAIL waw_sel got %0d want 2", sif.src_sel[5:3]); miscompares++;
        end
    endtask

    task automatic test_flash();
        do_reset();
        cand(0, 1, 0, 0, 2'b00, 5'd12, 1, 0);
        tick();
        cand(0, 1, 0, 0, 2'b00, 5'd10, 1, 0);
        tick();
        cand(0, 1, 0, 0, 2'b00, 5'd13, 1, 0);
        cand(1, 1, 0, 0, 2'b00, 5'd14, 1, 0);
        sif.flash_ex = 1'b1;
        #1;
        vectors++;
        if (sif.issue_num !== 2'd0) begin
            $display("FAIL flash_issue got %0d want 0", sif.issue_num); miscompares++;
        end
        tick();
        clear_cands();
        cand(0, 1, 5'd10, 5'd12, 2'b11, 0, 0, 0);
        cand(1, 1, 5'd13, 5'd14, 2'b11, 0, 0, 0);
        #1;
        vectors++;
        if (sif.src_sel !== {3'd0, 3'd0, 3'd5, 3'd0}) begin
            $display("FAIL flash_sel got %h want %h", sif.src_sel, {3'd0, 3'd0, 3'd5, 3'd0});
            miscompares++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        cand(0, 1, 0, 0, 2'b00, 5'd11, 1, 0);
        tick();
        sif.stall_adv = 1'b1;
        cand(0, 1, 5'd11, 0, 2'b01, 5'd15, 1, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (sif.issue_num !== 2'd0 || sif.src_sel[2:0] !== 3'd1 ||
                sif.hazard_stall_cnt !== 4'd0) begin
                $display("FAIL stall_hold%0d got issue=%0d sel=%0d cnt=%0d want 0/1/0", k,
                         sif.issue_num, sif.src_sel[2:0], sif.hazard_stall_cnt);
                miscompares++;
            end
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (sif.src_sel[2:0] !== 3'd0) begin
            $display("FAIL stall_reset_sel got %0d want 0", sif.src_sel[2:0]); miscompares++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            clear_cands();
            cand(0, 1, 0, 0, 2'b00, 5'd4, 1, 1);
            tick();
            cand(0, 1, 5'd4, 0, 2'b01, 0, 0, 0);
            tick();
            if (k == 9) begin
                vectors++;
                if (sif.hazard_stall_cnt !== 4'd10) begin
                    $display("FAIL sat_mid got %0d want 10", sif.hazard_stall_cnt); miscompares++;
                end
            end
        end
        vectors++;
        if (sif.hazard_stall_cnt !== 4'd15) begin
            $display("FAIL sat_final got %0d want 15", sif.hazard_stall_cnt); miscompares++;
        end
    endtask

    initial begin
        clear_cands();
        test_reset();
        test_independent();
        test_load_use();
        test_intra_raw();
        test_waw();
        test_flash();
        test_stall();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
